// File: rtl/wb_stream_writer_pkg.sv
// Shared Wishbone constants and state encoding for the stream writer.
package wb_stream_writer_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_BURST = 2'd2
   } state_t;

endpackage

// File: rtl/wb_stream_writer_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
module wb_stream_writer_fifo #(
   parameter int dw = 32,
   parameter int aw = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          wr_en,
   input  logic [dw-1:0] wr_data,
   input  logic          rd_en,
   output logic [dw-1:0] rd_data,
   output logic [aw:0]   count,
   output logic          full
);

   logic [dw-1:0] mem [2**aw];
   logic [aw-1:0] wr_ptr, rd_ptr;
   logic          wr_ok, rd_ok;

   assign full    = (count == (aw+1)'(2**aw));
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && (count != '0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok && !flush)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_stream_writer.sv
// Streams words from a valid/ready input into Wishbone incrementing write bursts.
module wb_stream_writer
   import wb_stream_writer_pkg::*;
#(
   parameter int dw        = 32,
   parameter int aw        = 32,
   parameter int max_burst = 8,
   parameter int fifo_aw   = 4
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          start_i,
   input  logic [aw-1:0] base_adr_i,
   input  logic [15:0]   len_i,
   input  logic [dw-1:0] stm_data_i,
   input  logic          stm_valid_i,
   output logic          stm_ready_o,
   output logic [aw-1:0] wb_adr_o,
   output logic [dw-1:0] wb_dat_o,
   output logic [3:0]    wb_sel_o,
   output logic          wb_we_o,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   output logic [2:0]    wb_cti_o,
   output logic [1:0]    wb_bte_o,
   input  logic          wb_ack_i,
   input  logic          wb_err_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o
);

   localparam int BW = $clog2(max_burst) + 1;

   state_t          state, state_nxt;
   logic [aw-1:0]   adr_q;
   logic [15:0]     len_q, accepted, remaining;
   logic [BW-1:0]   burst_len, beat_cnt, blen_calc;
   logic            err_q, done_q;
   logic [fifo_aw:0] fifo_cnt;
   logic            fifo_full, fifo_wr;
   logic [dw-1:0]   fifo_head;
   logic            start_ok, ack_ok, err_hit, last_beat, fill_ready;

   assign start_ok    = (state == S_IDLE) && start_i;
   assign ack_ok      = (state == S_BURST) && wb_ack_i && !wb_err_i;
   assign err_hit     = (state == S_BURST) && wb_err_i;
   assign last_beat   = (beat_cnt == burst_len - BW'(1));
   assign stm_ready_o = (state != S_IDLE) && !fifo_full && (accepted < len_q);
   assign fifo_wr     = stm_valid_i && stm_ready_o;

   always_comb begin
      blen_calc = BW'(max_burst);
      if (remaining < 16'(max_burst))
         blen_calc = remaining[BW-1:0];
   end

   // Enter a burst only once every beat of it is already buffered.
   assign fill_ready = 32'(fifo_cnt) >= 32'(blen_calc);

   wb_stream_writer_fifo #(.dw(dw), .aw(fifo_aw)) u_fifo (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .flush   (start_ok || err_hit),
      .wr_en   (fifo_wr),
      .wr_data (stm_data_i),
      .rd_en   (ack_ok),
      .rd_data (fifo_head),
      .count   (fifo_cnt),
      .full    (fifo_full)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start_i && len_i != 16'd0) state_nxt = S_FILL;
         S_FILL:  if (fill_ready) state_nxt = S_BURST;
         S_BURST: begin
            if (wb_err_i)
               state_nxt = S_IDLE;
            else if (wb_ack_i && last_beat)
               state_nxt = (remaining != 16'd1) ? S_FILL : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         adr_q     <= '0;
         len_q     <= '0;
         accepted  <= '0;
         remaining <= '0;
         burst_len <= '0;
         beat_cnt  <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_ok) begin
            err_q <= 1'b0;
            if (len_i == 16'd0) begin
               done_q <= 1'b1;
            end else begin
               adr_q     <= base_adr_i;
               len_q     <= len_i;
               remaining <= len_i;
               accepted  <= '0;
            end
         end
         if (fifo_wr)
            accepted <= accepted + 16'd1;
         if (state == S_FILL && fill_ready) begin
            burst_len <= blen_calc;
            beat_cnt  <= '0;
         end
         if (err_hit) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
         end else if (ack_ok) begin
            adr_q     <= adr_q + aw'(4);
            remaining <= remaining - 16'd1;
            beat_cnt  <= beat_cnt + BW'(1);
            if (last_beat && remaining == 16'd1)
               done_q <= 1'b1;
         end
      end
   end

   always_comb begin
      wb_cyc_o = 1'b0;
      wb_stb_o = 1'b0;
      wb_we_o  = 1'b0;
      wb_sel_o = 4'h0;
      wb_cti_o = CTI_CLASSIC;
      wb_bte_o = BTE_LINEAR;
      if (state == S_BURST) begin
         wb_cyc_o = 1'b1;
         wb_stb_o = 1'b1;
         wb_we_o  = 1'b1;
         wb_sel_o = 4'hf;
         wb_cti_o = last_beat ? CTI_EOB : CTI_INC;
      end
   end

   assign wb_adr_o = adr_q;
   assign wb_dat_o = fifo_head;
   assign busy_o   = (state != S_IDLE);
   assign done_o   = done_q;
   assign err_o    = err_q;

endmodule

// File: doc/wb_stream_writer.md
WB_STREAM_WRITER -- requirements
Module: wb_stream_writer

Interface
REQ-001 Parameter dw, 32, data width in bits (only 32 supported).
REQ-002 Parameter aw, 32, Wishbone byte-address width.
REQ-003 Parameter max_burst, 8, maximum beats per Wishbone burst (power of two, 1..16).
REQ-004 Parameter fifo_aw, 4, log2 of internal FIFO depth (depth >= max_burst).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset: wb_clk_i in 1 clock; wb_rst_i in 1 synchronous active-high reset.
REQ-006 start_i in 1: start pulse; base_adr_i in aw: start byte address (word aligned); len_i in 16: transfer length in words.
REQ-007 stm_data_i in dw, stm_valid_i in 1, stm_ready_o out 1: input word stream with valid/ready handshake.
REQ-008 wb_adr_o out aw, wb_dat_o out dw, wb_sel_o out 4, wb_we_o out 1, wb_cyc_o out 1, wb_stb_o out 1, wb_cti_o out 3, wb_bte_o out 2: Wishbone master outputs.
REQ-009 wb_ack_i in 1, wb_err_i in 1: Wishbone slave responses.
REQ-010 busy_o out 1: transfer active; done_o out 1: one-cycle completion pulse; err_o out 1: sticky bus-error flag.

Function
REQ-011 States SHALL be IDLE, FILL, BURST.
REQ-012 In IDLE, start_i SHALL latch base_adr_i and len_i, flush the FIFO, clear err_o, and enter FILL; if len_i==0, the block SHALL instead pulse done_o the next cycle and stay in IDLE.
REQ-013 start_i outside IDLE SHALL be ignored.
REQ-014 stm_ready_o SHALL be high only when state!=IDLE, the FIFO is not full, and accepted words < len; a word transfers when stm_valid_i & stm_ready_o.
REQ-015 The FIFO SHALL be first-word-fall-through; a written word SHALL be readable the following cycle.
REQ-016 Burst length SHALL be min(max_burst, remaining words), fixed on entry to BURST.
REQ-017 FILL SHALL go to BURST in the cycle after FIFO count >= burst length, so that no burst stalls for data.
REQ-018 In BURST: wb_cyc_o=wb_stb_o=wb_we_o=1, wb_sel_o=4'hf, wb_bte_o=2'b00, wb_dat_o=FIFO head.
REQ-019 wb_cti_o SHALL be 3'b010 on every beat except the last beat of a burst, which SHALL be 3'b111; a one-beat burst SHALL use 3'b111.
REQ-020 On each wb_ack_i: pop FIFO, wb_adr_o += 4, remaining -= 1; without ack, all master outputs SHALL hold.
REQ-021 After the last-beat ack, cyc/stb SHALL drop the next cycle; the state SHALL be FILL if remaining>0, else IDLE with done_o pulsed for one cycle.
REQ-022 wb_err_i during BURST SHALL drop cyc/stb the next cycle, set err_o, pulse done_o, flush the FIFO, and return to IDLE.
REQ-023 wb_ack_i/wb_err_i with wb_cyc_o low SHALL be ignored.
REQ-024 busy_o SHALL equal (state!=IDLE).
REQ-025 Address arithmetic SHALL wrap modulo 2^aw; a length of 65535 SHALL be supported.

Reset
REQ-026 wb_rst_i SHALL force IDLE, empty FIFO, and drive wb_cyc_o, wb_stb_o, wb_we_o, stm_ready_o, busy_o, done_o, err_o = 0, wb_adr_o=0, wb_cti_o=3'b000, wb_bte_o=2'b00, wb_sel_o=4'h0, all counters=0.
REQ-027 Reset mid-burst SHALL drop wb_cyc_o in the cycle after wb_rst_i is sampled, with no done_o pulse.

Structure
REQ-028 CTI/BTE constants (classic 000, incrementing 010, end-of-burst 111, linear 00) SHALL come from the shared Wishbone common header; no local redefinition.
REQ-029 The FIFO SHALL be one sub-module, wb_stream_writer_fifo (sync FIFO: count output, flush input, FWFT read).

Verification
REQ-030 base=0x100, len=3, 3 words preloaded, ack every cycle -> one burst at 0x100/0x104/0x108, cti 010,010,111, done_o one pulse.
REQ-031 len=20, max_burst=8 -> bursts of 8, 8, 4 beats; addresses contiguous from base; last beat of each burst cti=111.
REQ-032 len=1 -> single beat, cti=111; len=0 -> no cyc, done_o pulse the cycle after start_i.
REQ-033 Slave inserts 2 wait cycles per beat and stm_valid_i is toggled randomly -> outputs held stable while no ack; data written equals input order; stm_ready_o low after 20 words accepted.
REQ-034 wb_err_i on beat 2 of 8 -> cyc low the next cycle, err_o=1, done_o pulse, busy_o=0; next start_i clears err_o.
REQ-035 wb_rst_i asserted mid-burst -> all outputs at reset values the next cycle; a subsequent start_i runs a normal transfer.
